// File: rtl/modport_counter_pkg.sv
// -----------------------------------------------------------------------------
// modport_counter_pkg
// Shared definitions for the loadable up/down counter slice.
//   WIDTH_DEF   : default counter width in bits
//   MAX_VAL_DEF : default terminal value (all ones for WIDTH_DEF)
//   cnt_t       : count/data type at the default width
//   dir_e       : direction encoding of the up_down control
// -----------------------------------------------------------------------------
package modport_counter_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int MAX_VAL_DEF = (2 ** WIDTH_DEF) - 1;

    typedef logic [WIDTH_DEF-1:0] cnt_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

endpackage : modport_counter_pkg

// File: rtl/modport_counter_if.sv
// -----------------------------------------------------------------------------
// modport_counter_if
// Bundles the counter control/data signals between a driver and the counter.
//   load    : synchronous parallel-load request
//   up_down : direction select, 1 = up, 0 = down
//   data_in : parallel load value
//   count   : registered counter value
// Modports:
//   master : driver side (drives controls, observes count)
//   slave  : counter side (receives controls, drives count)
// -----------------------------------------------------------------------------
interface modport_counter_if
    import modport_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             load;
    logic             up_down;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;

    modport master (
        output load,
        output up_down,
        output data_in,
        input  count
    );

    modport slave (
        input  load,
        input  up_down,
        input  data_in,
        output count
    );

endinterface : modport_counter_if

// File: rtl/modport_counter_next_val.sv
// -----------------------------------------------------------------------------
// modport_counter_next_val
// Combinational next-state logic of the counter.
//   load_i       : take the (saturated) load value
//   up_down_i    : 1 = wrap-increment, 0 = wrap-decrement
//   data_i       : parallel load value
//   count_i      : current registered count
//   count_next_o : value the register takes at the next clock edge
// Counting range is 0..MAX_VAL; loads above MAX_VAL clamp to MAX_VAL.
// -----------------------------------------------------------------------------
module modport_counter_next_val
    import modport_counter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
    input  logic             load_i,
    input  logic             up_down_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [WIDTH-1:0] count_next_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    always_comb begin
        count_next_o = count_i;
        if (load_i) begin
            // Saturating load keeps the counter inside its legal range
            count_next_o = (data_i > MAX_C) ? MAX_C : data_i;
        end else if (up_down_i == UP) begin
            count_next_o = (count_i == MAX_C) ? '0 : (count_i + 1'b1);
        end else begin
            count_next_o = (count_i == '0) ? MAX_C : (count_i - 1'b1);
        end
    end

endmodule : modport_counter_next_val

// File: rtl/modport_counter.sv
// -----------------------------------------------------------------------------
// modport_counter
// Loadable, wrapping up/down counter with asynchronous active-low reset.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset, clears count
//   bus    : slave modport carrying load, up_down, data_in (in) and count (out)
// The counter advances every cycle (no enable); load has priority over
// counting. count comes straight from a register.
// -----------------------------------------------------------------------------
module modport_counter
    import modport_counter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
    input  logic             clock,
    input  logic             resetn,
    modport_counter_if.slave bus
);

    // Reject builds whose terminal value cannot be represented or is empty
    generate
        if ((MAX_VAL < 1) || (MAX_VAL > (2 ** WIDTH) - 1)) begin : g_bad_max
            $error("modport_counter: MAX_VAL out of range 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    modport_counter_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_val (
        .load_i       (bus.load),
        .up_down_i    (bus.up_down),
        .data_i       (bus.data_in),
        .count_i      (count_q),
        .count_next_o (count_d)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;

`ifndef SYNTHESIS
    // Count is held at zero for as long as reset is asserted
    a_reset_value: assert property (@(posedge clock)
        !resetn |-> (count_q == '0))
        else $error("modport_counter: count not zero in reset");

    a_wrap_up: assert property (@(posedge clock) disable iff (!resetn)
        (!bus.load && bus.up_down && (count_q == MAX_C)) |=> (count_q == '0))
        else $error("modport_counter: up count did not wrap to zero");

    a_wrap_down: assert property (@(posedge clock) disable iff (!resetn)
        (!bus.load && !bus.up_down && (count_q == '0)) |=> (count_q == MAX_C))
        else $error("modport_counter: down count did not wrap to MAX_VAL");

    a_load_sat: assert property (@(posedge clock) disable iff (!resetn)
        (bus.load && (bus.data_in > MAX_C)) |=> (count_q == MAX_C))
        else $error("modport_counter: oversized load not saturated");

    a_count_known: assert property (@(posedge clock) disable iff (!resetn)
        !$isunknown(count_q))
        else $error("modport_counter: count unknown out of reset");

    a_ctrl_known: assert property (@(posedge clock) disable iff (!resetn)
        !$isunknown({bus.load, bus.up_down}))
        else $error("modport_counter: load/up_down unknown out of reset");
`endif

endmodule : modport_counter

// File: tb/tb_modport_counter.sv
// -----------------------------------------------------------------------------
// tb_modport_counter
// Drives two counters (full range and MAX_VAL=11) through their interfaces,
// tracks both with an arithmetic reference model and compares every cycle,
// plus directed sequences with hand-computed values.
// -----------------------------------------------------------------------------
module tb_modport_counter;

    localparam int W     = 4;
    localparam int MAX_A = 15;
    localparam int MAX_B = 11;

    logic clock;
    logic resetn;

    modport_counter_if #(.WIDTH(W)) if_a ();
    modport_counter_if #(.WIDTH(W)) if_b ();

    modport_counter #(.WIDTH(W), .MAX_VAL(MAX_A)) dut_a (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if_a.slave)
    );

    modport_counter #(.WIDTH(W), .MAX_VAL(MAX_B)) dut_b (
        .clock  (clock),
        .resetn (resetn),
        .bus    (if_b.slave)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    int ma = 0;
    int mb = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Range 0..maxv treated as a ring of maxv+1 values
    function automatic int model_next(input int m, input int maxv, input bit ld,
                                      input bit up, input int d);
        if (ld) return (d > maxv) ? maxv : d;
        if (up) return (m + 1) % (maxv + 1);
        return (m + maxv) % (maxv + 1);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ma <= 0;
            mb <= 0;
        end else begin
            ma <= model_next(ma, MAX_A, if_a.load, if_a.up_down, int'(if_a.data_in));
            mb <= model_next(mb, MAX_B, if_b.load, if_b.up_down, int'(if_b.data_in));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cycle_a", int'(if_a.count), ma);
            chk("cycle_b", int'(if_b.count), mb);
        end
    end

    // Called at 1 time unit after a rising edge; returns at the same phase
    task automatic step(input bit ld, input bit up, input int d);
        if_a.load    = ld;
        if_a.up_down = up;
        if_a.data_in = W'(d);
        if_b.load    = ld;
        if_b.up_down = up;
        if_b.data_in = W'(d);
        @(posedge clock);
        #1;
        $display("step load=%0d up=%0d data=%0d -> a=%0d b=%0d",
                 ld, up, d, if_a.count, if_b.count);
    endtask

    initial begin
        resetn       = 1'b0;
        if_a.load    = 1'b0;
        if_a.up_down = 1'b1;
        if_a.data_in = '0;
        if_b.load    = 1'b0;
        if_b.up_down = 1'b1;
        if_b.data_in = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_a", int'(if_a.count), 0);
        chk("reset_b", int'(if_b.count), 0);
        resetn = 1'b1;
        cmp_en = 1'b1;

        // Load then count up
        step(1, 1, 9);  chk("load9", int'(if_a.count), 9);
        step(0, 1, 0);  chk("load9_up", int'(if_a.count), 10);

        // Up wrap
        step(1, 1, 14);
        step(0, 1, 0);  chk("upwrap_15", int'(if_a.count), 15);
        step(0, 1, 0);  chk("upwrap_0", int'(if_a.count), 0);
        step(0, 1, 0);  chk("upwrap_1", int'(if_a.count), 1);

        // Down wrap
        step(1, 0, 1);
        step(0, 0, 0);  chk("dnwrap_0", int'(if_a.count), 0);
        step(0, 0, 0);  chk("dnwrap_15", int'(if_a.count), 15);
        step(0, 0, 0);  chk("dnwrap_14", int'(if_a.count), 14);

        // Direction flip and load priority
        step(1, 1, 5);
        step(0, 1, 0);  chk("flip_6", int'(if_a.count), 6);
        step(0, 1, 0);  chk("flip_7", int'(if_a.count), 7);
        step(0, 0, 0);  chk("flip_6b", int'(if_a.count), 6);
        step(1, 0, 3);  chk("load_wins", int'(if_a.count), 3);

        // Saturating load and wrap on the MAX_VAL=11 counter
        step(1, 1, 13); chk("sat_b", int'(if_b.count), 11);
                        chk("nosat_a", int'(if_a.count), 13);
        step(0, 1, 0);  chk("sat_b_up", int'(if_b.count), 0);
        step(0, 0, 0);  chk("sat_b_dn", int'(if_b.count), 11);
                        chk("sat_a_dn", int'(if_a.count), 13);

        // Asynchronous reset between edges
        step(1, 1, 7);  chk("pre_rst", int'(if_a.count), 7);
        if_a.load = 1'b0;
        if_b.load = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_a", int'(if_a.count), 0);
        chk("async_rst_b", int'(if_b.count), 0);
        @(posedge clock);
        #1;
        chk("rst_hold", int'(if_a.count), 0);
        resetn = 1'b1;
        #3;
        chk("rel_wait", int'(if_a.count), 0);
        @(posedge clock);
        #1;
        chk("rel_first_a", int'(if_a.count), 1);
        chk("rel_first_b", int'(if_b.count), 1);

        // Randomised traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 400; i++) begin
            if_a.load    = ($urandom_range(0, 4) == 0);
            if_a.up_down = $urandom_range(0, 1) == 1;
            if_a.data_in = W'($urandom_range(0, 15));
            if_b.load    = ($urandom_range(0, 4) == 0);
            if_b.up_down = $urandom_range(0, 1) == 1;
            if_b.data_in = W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                #1;
                resetn = 1'b0;
                #1;
                resetn = 1'b1;
            end
            @(posedge clock);
            #1;
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_modport_counter
